// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Error-cause bit positions are reserved for a future status register.
package dmem_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t WAIT = 2'd1;
   localparam state_t RESP = 2'd2;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned ADDR_LSB   = 2;

   localparam int unsigned ERR_RANGE = 0;
   localparam int unsigned ERR_ALIGN = 1;
   localparam int unsigned NUM_ERR   = 2;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
   import dmem_pkg::*;

   logic                  req_i;
   logic                  we_i;
   logic [31:0]           addr_i;
   logic [31:0]           wdata_i;
   logic [WORD_BYTES-1:0] be_i;
   logic                  ready_o;
   logic                  ack_o;
   logic [31:0]           rdata_o;
   logic                  err_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i,
      input  ready_o, ack_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i,
      output ready_o, ack_o, rdata_o, err_o
   );

endinterface

// File: rtl/dmem_word_array.sv
// Single-port synchronous word array with per-byte-lane write enables and a registered read.
module dmem_word_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic [IDX_W-1:0]      index_i,
   input  logic                  we_i,
   input  logic [WORD_BYTES-1:0] be_i,
   input  logic [31:0]           wdata_i,
   input  logic                  re_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (be_i[b]) mem[index_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
      if (re_i) rdata_o <= mem[index_i];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake, configurable wait states, address range and
// alignment checking, byte-enabled stores and full-word loads.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_MEMORY_DEPTH = 256,
   parameter int unsigned WAIT_STATES       = 2,
   parameter logic [31:0] BASE_ADDR         = 32'h1001_0000
) (
   input logic              clk,
   input logic              reset,
   dmem_responder_if.slave  bus
);

   localparam int unsigned IDX_W     = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;
   localparam logic [31:0] SPAN      = 32'(DATA_MEMORY_DEPTH * WORD_BYTES);
   localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q;
   logic [31:0]           addr_q;
   logic [31:0]           wdata_q;
   logic [WORD_BYTES-1:0] be_q;
   logic                  err_q;

   logic                  accept;
   logic                  commit;
   logic                  acc_we;
   logic [31:0]           acc_addr;
   logic [31:0]           acc_wdata;
   logic [WORD_BYTES-1:0] acc_be;
   logic [31:0]           offset;
   logic [NUM_ERR-1:0]    err_cause;
   logic                  acc_err;
   logic [IDX_W-1:0]      index;
   logic [31:0]           arr_rdata;

   assign accept = (state_q == IDLE) && bus.req_i;

   // With zero wait states the commit happens on the accept edge, so decode the live inputs.
   always_comb begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      if (state_q == IDLE) begin
         acc_we    = bus.we_i;
         acc_addr  = bus.addr_i;
         acc_wdata = bus.wdata_i;
         acc_be    = bus.be_i;
      end
   end

   // Unsigned subtraction: addresses below the base wrap to a huge offset and fail the range test.
   assign offset               = acc_addr - BASE_ADDR;
   assign err_cause[ERR_RANGE] = offset >= SPAN;
   assign err_cause[ERR_ALIGN] = |acc_addr[ADDR_LSB-1:0];
   assign acc_err              = |err_cause;
   assign index                = offset[ADDR_LSB +: IDX_W];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_i) begin
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign commit = !reset && (state_d == RESP) && (state_q != RESP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
            be_q    <= bus.be_i;
         end
         if (commit) err_q <= acc_err;
      end
   end

   dmem_word_array #(
      .DEPTH (DATA_MEMORY_DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .index_i (index),
      .we_i    (commit && acc_we && !acc_err),
      .be_i    (acc_be),
      .wdata_i (acc_wdata),
      .re_i    (commit && !acc_we && !acc_err),
      .rdata_o (arr_rdata)
   );

   assign bus.ready_o = (state_q == IDLE);
   assign bus.ack_o   = (state_q == RESP);
   assign bus.err_o   = bus.ack_o && err_q;
   assign bus.rdata_o = (bus.ack_o && !we_q && !err_q) ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_STATES=2 instance driven from a vector table
// and a WAIT_STATES=0 instance, with expected responses queued at acceptance.
module tb_dmem_responder;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   exp_t q2[$];
   exp_t q0[$];
   exp_t e2, e0;
   vec_t tbl [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder_if bus2();
   dmem_responder_if bus0();

   dmem_responder #(
      .DATA_MEMORY_DEPTH (256),
      .WAIT_STATES       (2),
      .BASE_ADDR         (32'h1001_0000)
   ) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   dmem_responder #(
      .DATA_MEMORY_DEPTH (256),
      .WAIT_STATES       (0),
      .BASE_ADDR         (32'h1001_0000)
   ) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive a request on the chosen bus and hold it until accepted; req stays high afterwards.
   task automatic issue(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err, input bit push,
                        output int acc);
      bit rdy;
      bit ok;
      int c;
      ok  = 1'b0;
      c   = 0;
      acc = 0;
      @(negedge clk);
      if (sel) begin
         bus0.req_i = 1'b1; bus0.we_i = we; bus0.addr_i = addr;
         bus0.wdata_i = wdata; bus0.be_i = be;
      end else begin
         bus2.req_i = 1'b1; bus2.we_i = we; bus2.addr_i = addr;
         bus2.wdata_i = wdata; bus2.be_i = be;
      end
      for (int k = 0; k < 50; k++) begin
         if (k > 0) @(negedge clk);
         rdy = sel ? bus0.ready_o : bus2.ready_o;
         c   = cyc;
         @(posedge clk);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout: ready_o stayed 0, required 1 within 50 cycles");
      end else begin
         acc = c + 1;
         if (push) begin
            if (sel) q0.push_back('{exp_rd, exp_err, acc});
            else     q2.push_back('{exp_rd, exp_err, acc + 2});
         end
      end
   endtask

   always @(negedge clk) begin
      if (bus2.ack_o === 1'b1) begin
         if (q2.size() == 0) begin
            chk("ack2_unexpected", 32'(bus2.ack_o), 32'd0);
         end else begin
            e2 = q2.pop_front();
            chk("w2_rdata", bus2.rdata_o, e2.rd);
            chk("w2_err", 32'(bus2.err_o), 32'(e2.err));
            chk("w2_ack_cycle", 32'(cyc), 32'(e2.cyc));
         end
      end
      if (bus0.ack_o === 1'b1) begin
         if (q0.size() == 0) begin
            chk("ack0_unexpected", 32'(bus0.ack_o), 32'd0);
         end else begin
            e0 = q0.pop_front();
            chk("w0_rdata", bus0.rdata_o, e0.rd);
            chk("w0_err", 32'(bus0.err_o), 32'(e0.err));
            chk("w0_ack_cycle", 32'(cyc), 32'(e0.cyc));
         end
      end
   end

   initial begin
      int acc, prev;

      tbl[0]  = '{1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
      tbl[1]  = '{1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
      tbl[2]  = '{1'b1, 32'h1001_0008, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
      tbl[3]  = '{1'b1, 32'h1001_0008, 32'h0000_00AA, 4'h1, 32'h0,         1'b0};
      tbl[4]  = '{1'b0, 32'h1001_0008, 32'h0,         4'h0, 32'h1122_33AA, 1'b0};
      tbl[5]  = '{1'b1, 32'h1001_0000, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
      tbl[6]  = '{1'b0, 32'h1001_0002, 32'h0,         4'h0, 32'h0,         1'b1};
      tbl[7]  = '{1'b1, 32'h1001_0400, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
      tbl[8]  = '{1'b0, 32'h1001_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
      tbl[9]  = '{1'b0, 32'h1000_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};
      tbl[10] = '{1'b1, 32'h1001_0004, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
      tbl[11] = '{1'b1, 32'h1001_0004, 32'h7777_7777, 4'hA, 32'h0,         1'b0};
      tbl[12] = '{1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'h77AD_77EF, 1'b0};
      tbl[13] = '{1'b1, 32'h1001_03FC, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0};
      tbl[14] = '{1'b0, 32'h1001_03FC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
      tbl[15] = '{1'b1, 32'h1001_000C, 32'h1111_1111, 4'hF, 32'h0,         1'b0};

      bus2.req_i = 1'b0; bus2.we_i = 1'b0; bus2.addr_i = '0; bus2.wdata_i = '0; bus2.be_i = '0;
      bus0.req_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = '0; bus0.wdata_i = '0; bus0.be_i = '0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_ready2", 32'(bus2.ready_o), 32'd1);
      chk("rst_ack2",   32'(bus2.ack_o),   32'd0);
      chk("rst_rdata2", bus2.rdata_o,      32'd0);
      chk("rst_err2",   32'(bus2.err_o),   32'd0);
      chk("rst_ready0", 32'(bus0.ready_o), 32'd1);
      chk("rst_ack0",   32'(bus0.ack_o),   32'd0);
      chk("rst_rdata0", bus0.rdata_o,      32'd0);
      chk("rst_err0",   32'(bus0.err_o),   32'd0);

      // req_i stays high between table entries, so accepts must come every 4 cycles.
      prev = 0;
      for (int i = 0; i < 16; i++) begin
         issue(1'b0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].rd, tbl[i].err,
               1'b1, acc);
         if (i > 0) chk("w2_accept_spacing", 32'(acc - prev), 32'd4);
         else begin
            @(negedge clk);
            chk("w2_ready_after_accept", 32'(bus2.ready_o), 32'd0);
         end
         prev = acc;
      end

      // Store dropped by a reset while in WAIT: no ack, no write.
      issue(1'b0, 1'b1, 32'h1001_000C, 32'h5555_5555, 4'hF, 32'h0, 1'b0, 1'b0, acc);
      @(negedge clk);
      bus2.req_i = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_wait_ready", 32'(bus2.ready_o), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("reset_wait_no_ack", 32'(bus2.ack_o), 32'd0);
      end
      issue(1'b0, 1'b0, 32'h1001_000C, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 1'b1, acc);
      @(negedge clk);
      bus2.req_i = 1'b0;

      issue(1'b1, 1'b1, 32'h1001_0010, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1'b1, acc);
      prev = acc;
      issue(1'b1, 1'b0, 32'h1001_0010, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b1, acc);
      chk("w0_accept_spacing", 32'(acc - prev), 32'd2);
      prev = acc;
      issue(1'b1, 1'b0, 32'h1001_0011, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, acc);
      chk("w0_accept_spacing", 32'(acc - prev), 32'd2);
      prev = acc;
      issue(1'b1, 1'b1, 32'h1001_0400, 32'hFFFF_0000, 4'hF, 32'h0, 1'b1, 1'b1, acc);
      chk("w0_accept_spacing", 32'(acc - prev), 32'd2);
      @(negedge clk);
      bus0.req_i = 1'b0;

      repeat (8) @(negedge clk);
      chk("w2_outstanding", 32'(q2.size()), 32'd0);
      chk("w0_outstanding", 32'(q0.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
